// File: rtl/apb_rr_pkg.sv
// Shared types and default widths for the round-robin APB master.
package apb_rr_pkg;

    localparam int APB_AW = 8;
    localparam int APB_DW = 21;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

endpackage

// File: rtl/apb_rr_if.sv
// APB bus between the round-robin master and the memory slave, including the PWAIT
// side-band that sets the slave's wait-state count.
interface apb_rr_if
    import apb_rr_pkg::*;
#(
    parameter int AW = APB_AW,
    parameter int DW = APB_DW
) ();

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [WAIT_W-1:0] PWAIT;
    logic              PREADY;
    logic [DW-1:0]     PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT,
        input  PREADY, PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT,
        output PREADY, PRDATA
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one APB slave among NREQ requesters, one transfer in flight.
// Define APB_RR_TIMEOUT_EN to build the ACCESS-phase timeout abort (done + err, rdata cleared).
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 32
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [WAIT_W-1:0]  cfg_wait,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    apb_rr_if.master           apb
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 256) begin : g_param_check
        $error("apb_rr_master: NREQ or TIMEOUT out of range");
    end

    state_e              state_q, state_n;
    logic [PW-1:0]       ptr_q, ptr_n, idx_q, idx_n, ptr_inc;
    logic [NREQ-1:0]     sel_q, sel_n, grant_n, done_n;
    logic                psel_q, psel_n, penable_q, penable_n, pwrite_q, pwrite_n;
    logic [AW-1:0]       paddr_q, paddr_n;
    logic [DW-1:0]       pwdata_q, pwdata_n, rdata_n;
    logic [WAIT_W-1:0]   pwait_q, pwait_n;
    logic                launch;

    logic [NREQ-1:0]     arb_req, arb_gnt;
    logic [PW-1:0]       arb_ptr, arb_idx;
    logic                arb_valid;

`ifdef APB_RR_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]          cnt_q, cnt_n;
    logic                err_n;
`endif

    // On completion the finishing requester is masked and the search starts just past it.
    assign ptr_inc = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
    assign arb_req = (state_q == ACCESS) ? (req & ~sel_q) : req;
    assign arb_ptr = (state_q == ACCESS) ? ptr_inc : ptr_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (arb_req),
        .ptr   (arb_ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (arb_gnt[i]) arb_idx = PW'(i);
    end

    always_comb begin
        state_n   = state_q;
        ptr_n     = ptr_q;
        idx_n     = idx_q;
        sel_n     = sel_q;
        psel_n    = psel_q;
        penable_n = penable_q;
        pwrite_n  = pwrite_q;
        paddr_n   = paddr_q;
        pwdata_n  = pwdata_q;
        pwait_n   = pwait_q;
        rdata_n   = rdata;
        grant_n   = '0;
        done_n    = '0;
        launch    = 1'b0;
`ifdef APB_RR_TIMEOUT_EN
        cnt_n     = cnt_q;
        err_n     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                psel_n    = 1'b0;
                penable_n = 1'b0;
                launch    = arb_valid;
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
`ifdef APB_RR_TIMEOUT_EN
                cnt_n     = '0;
`endif
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    done_n    = sel_q;
                    ptr_n     = ptr_inc;
                    penable_n = 1'b0;
                    if (!pwrite_q) rdata_n = apb.PRDATA;
                    if (arb_valid) begin
                        launch = 1'b1;
                    end else begin
                        psel_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
`ifdef APB_RR_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    done_n    = sel_q;
                    err_n     = 1'b1;
                    rdata_n   = '0;
                    ptr_n     = ptr_inc;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        // Request fields are captured once here and never resampled during the transfer.
        if (launch) begin
            state_n   = SETUP;
            psel_n    = 1'b1;
            penable_n = 1'b0;
            grant_n   = arb_gnt;
            sel_n     = arb_gnt;
            idx_n     = arb_idx;
            pwrite_n  = req_write[arb_idx];
            paddr_n   = req_addr[arb_idx*AW +: AW];
            pwdata_n  = req_write[arb_idx] ? req_wdata[arb_idx*DW +: DW] : '0;
            pwait_n   = cfg_wait;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwait_q   <= '0;
            grant     <= '0;
            done      <= '0;
            rdata     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q   <= state_n;
            ptr_q     <= ptr_n;
            idx_q     <= idx_n;
            sel_q     <= sel_n;
            psel_q    <= psel_n;
            penable_q <= penable_n;
            pwrite_q  <= pwrite_n;
            paddr_q   <= paddr_n;
            pwdata_q  <= pwdata_n;
            pwait_q   <= pwait_n;
            grant     <= grant_n;
            done      <= done_n;
            rdata     <= rdata_n;
        end
    end

`ifdef APB_RR_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
            err   <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            err   <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWAIT   = pwait_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: vector table for contention and a single read, plus
// hand-written write-with-waits, mid-transfer reset, withdrawn request and long-stall sequences.
module tb_apb_rr_master;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 21;

    logic               PCLK = 1'b0;
    logic               PRESET;
    logic [NREQ-1:0]    req, req_write, grant, done;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [3:0]         cfg_wait;
    logic [DW-1:0]      rdata;
    logic               err;

    int checks = 0;
    int errors = 0;

    apb_rr_if #(.AW(AW), .DW(DW)) bus ();

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(32)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .cfg_wait  (cfg_wait),
        .grant     (grant),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .apb       (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [3:0]  req;
        logic        pready;
        logic [20:0] prdata;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        psel;
        logic        pen;
        logic [7:0]  paddr;
        logic [20:0] rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;

        // Contention from pointer 0 with immediate PREADY, then a single read of requester 2.
        vecs[0]  = '{4'b1111, 1'b1, 21'h00101, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'h05, 21'h00000};
        vecs[1]  = '{4'b1111, 1'b1, 21'h00102, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h05, 21'h00000};
        vecs[2]  = '{4'b1111, 1'b1, 21'h00103, 4'b0010, 4'b0001, 1'b1, 1'b0, 8'h21, 21'h00103};
        vecs[3]  = '{4'b1111, 1'b1, 21'h00104, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h21, 21'h00103};
        vecs[4]  = '{4'b1111, 1'b1, 21'h00105, 4'b0100, 4'b0010, 1'b1, 1'b0, 8'h10, 21'h00105};
        vecs[5]  = '{4'b1111, 1'b1, 21'h00106, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h10, 21'h00105};
        vecs[6]  = '{4'b1111, 1'b1, 21'h00107, 4'b1000, 4'b0100, 1'b1, 1'b0, 8'h3C, 21'h00107};
        vecs[7]  = '{4'b1111, 1'b1, 21'h00108, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h3C, 21'h00107};
        vecs[8]  = '{4'b1111, 1'b1, 21'h00109, 4'b0001, 4'b1000, 1'b1, 1'b0, 8'h05, 21'h00109};
        vecs[9]  = '{4'b1111, 1'b1, 21'h0010A, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h05, 21'h00109};
        vecs[10] = '{4'b0000, 1'b1, 21'h0010B, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'h05, 21'h0010B};
        vecs[11] = '{4'b0000, 1'b0, 21'h00000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h05, 21'h0010B};
        vecs[12] = '{4'b0100, 1'b0, 21'h00000, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'h10, 21'h0010B};
        vecs[13] = '{4'b0100, 1'b1, 21'h0ABCD, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h10, 21'h0010B};
        vecs[14] = '{4'b0100, 1'b1, 21'h0ABCD, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'h10, 21'h0ABCD};
        vecs[15] = '{4'b0000, 1'b0, 21'h00000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 21'h0ABCD};

        PRESET     = 1'b1;
        req        = '0;
        req_write  = '0;
        cfg_wait   = '0;
        req_addr   = {8'h3C, 8'h10, 8'h21, 8'h05};
        req_wdata  = {21'h15555, 21'h0AAAA, 21'h00111, 21'h1FFFF};
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;

        #12;
        check("reset grant",   32'(grant),       32'h0);
        check("reset done",    32'(done),        32'h0);
        check("reset PSEL",    32'(bus.PSEL),    32'h0);
        check("reset PENABLE", 32'(bus.PENABLE), 32'h0);
        check("reset PADDR",   32'(bus.PADDR),   32'h0);
        check("reset PWDATA",  32'(bus.PWDATA),  32'h0);
        check("reset PWAIT",   32'(bus.PWAIT),   32'h0);
        check("reset rdata",   32'(rdata),       32'h0);
        check("reset err",     32'(err),         32'h0);
        tick();
        PRESET = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req        = vecs[i].req;
            bus.PREADY = vecs[i].pready;
            bus.PRDATA = vecs[i].prdata;
            tick();
            check($sformatf("v%0d grant", i),   32'(grant),       32'(vecs[i].grant));
            check($sformatf("v%0d done", i),    32'(done),        32'(vecs[i].done));
            check($sformatf("v%0d PSEL", i),    32'(bus.PSEL),    32'(vecs[i].psel));
            check($sformatf("v%0d PENABLE", i), 32'(bus.PENABLE), 32'(vecs[i].pen));
            check($sformatf("v%0d PADDR", i),   32'(bus.PADDR),   32'(vecs[i].paddr));
            check($sformatf("v%0d rdata", i),   32'(rdata),       32'(vecs[i].rdata));
            check($sformatf("v%0d err", i),     32'(err),         32'h0);
        end

        // Write with three wait states; pointer is 3 so requester 0 wins by wrap-around.
        req = 4'b0001; req_write = 4'b0001; cfg_wait = 4'd3; bus.PREADY = 1'b0;
        tick();
        check("wr grant",   32'(grant),       32'h1);
        check("wr PSEL",    32'(bus.PSEL),    32'h1);
        check("wr PENABLE", 32'(bus.PENABLE), 32'h0);
        check("wr PWRITE",  32'(bus.PWRITE),  32'h1);
        check("wr PADDR",   32'(bus.PADDR),   32'h05);
        check("wr PWDATA",  32'(bus.PWDATA),  32'h1FFFF);
        check("wr PWAIT",   32'(bus.PWAIT),   32'h3);
        req_addr[7:0] = 8'h77; req_wdata[20:0] = 21'h00001; cfg_wait = 4'd9; req_write = 4'b0000;
        tick();
        check("wr access PENABLE", 32'(bus.PENABLE), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wr wait%0d PENABLE", i), 32'(bus.PENABLE), 32'h1);
            check($sformatf("wr wait%0d PADDR", i),   32'(bus.PADDR),   32'h05);
            check($sformatf("wr wait%0d PWDATA", i),  32'(bus.PWDATA),  32'h1FFFF);
            check($sformatf("wr wait%0d PWAIT", i),   32'(bus.PWAIT),   32'h3);
            check($sformatf("wr wait%0d PWRITE", i),  32'(bus.PWRITE),  32'h1);
            check($sformatf("wr wait%0d done", i),    32'(done),        32'h0);
        end
        bus.PREADY = 1'b1; bus.PRDATA = 21'h12345;
        tick();
        check("wr done",    32'(done),        32'h1);
        check("wr rdata",   32'(rdata),       32'h0ABCD);
        check("wr PSEL",    32'(bus.PSEL),    32'h0);
        check("wr PENABLE", 32'(bus.PENABLE), 32'h0);
        req = '0; req_addr[7:0] = 8'h05; req_wdata[20:0] = 21'h1FFFF; cfg_wait = '0; bus.PREADY = 1'b0;
        tick();
        check("wr idle done", 32'(done), 32'h0);

        // Reset while PENABLE is high: asynchronous clear and no done for the aborted transfer.
        req = 4'b0010;
        tick();
        check("rst grant", 32'(grant), 32'h2);
        tick();
        check("rst PENABLE before", 32'(bus.PENABLE), 32'h1);
        bus.PREADY = 1'b1; bus.PRDATA = 21'h1F1F1;
        #2 PRESET = 1'b1;
        #1;
        check("rst async PSEL",    32'(bus.PSEL),    32'h0);
        check("rst async PENABLE", 32'(bus.PENABLE), 32'h0);
        check("rst async PADDR",   32'(bus.PADDR),   32'h0);
        check("rst async rdata",   32'(rdata),       32'h0);
        check("rst async grant",   32'(grant),       32'h0);
        tick();
        check("rst no done", 32'(done), 32'h0);
        PRESET = 1'b0; req = 4'b1001; bus.PREADY = 1'b0;
        tick();
        check("post-rst grant from 0", 32'(grant),     32'h1);
        check("post-rst PADDR",        32'(bus.PADDR), 32'h05);
        req = 4'b1000;
        tick();
        bus.PREADY = 1'b1; bus.PRDATA = 21'h00ABC;
        tick();
        check("b2b done",    32'(done),        32'h1);
        check("b2b grant",   32'(grant),       32'h8);
        check("b2b PSEL",    32'(bus.PSEL),    32'h1);
        check("b2b PENABLE", 32'(bus.PENABLE), 32'h0);
        check("b2b PADDR",   32'(bus.PADDR),   32'h3C);
        check("b2b rdata",   32'(rdata),       32'h00ABC);
        tick();
        check("b2b PENABLE", 32'(bus.PENABLE), 32'h1);
        bus.PRDATA = 21'h0F0F0;
        tick();
        check("b2b done 3", 32'(done),     32'h8);
        check("b2b rdata 3", 32'(rdata),   32'h0F0F0);
        check("b2b PSEL end", 32'(bus.PSEL), 32'h0);
        req = '0; bus.PREADY = 1'b0;
        tick();

        // Requester 1 withdraws right after its grant; the transfer still completes.
        req = 4'b0010;
        tick();
        check("wd grant", 32'(grant), 32'h2);
        req = '0;
        tick();
        check("wd PENABLE", 32'(bus.PENABLE), 32'h1);
        bus.PREADY = 1'b1; bus.PRDATA = 21'h05A5A;
        tick();
        check("wd done",  32'(done),     32'h2);
        check("wd rdata", 32'(rdata),    32'h05A5A);
        check("wd PSEL",  32'(bus.PSEL), 32'h0);
        bus.PREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wd no regrant%0d", i), 32'(grant),    32'h0);
            check($sformatf("wd idle PSEL%0d", i),  32'(bus.PSEL), 32'h0);
        end

        // PREADY held low in ACCESS: timeout abort when enabled, otherwise an indefinite stall.
        req = 4'b0100;
        tick();
        check("stall grant", 32'(grant), 32'h4);
        tick();
        bad = 0;
`ifdef APB_RR_TIMEOUT_EN
        for (int i = 0; i < 31; i++) begin
            tick();
            if (done != '0 || err) bad++;
        end
        check("to no early abort", 32'(bad), 32'h0);
        tick();
        check("to done",    32'(done),        32'h4);
        check("to err",     32'(err),         32'h1);
        check("to rdata",   32'(rdata),       32'h0);
        check("to PSEL",    32'(bus.PSEL),    32'h0);
        check("to PENABLE", 32'(bus.PENABLE), 32'h0);
        req = '0;
        tick();
        check("to err pulse", 32'(err), 32'h0);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.PENABLE || !bus.PSEL || done != '0 || err) bad++;
        end
        check("stall holds ACCESS", 32'(bad), 32'h0);
        bus.PREADY = 1'b1; bus.PRDATA = 21'h00777;
        tick();
        check("stall done",  32'(done),  32'h4);
        check("stall rdata", 32'(rdata), 32'h00777);
        check("stall err",   32'(err),   32'h0);
        req = '0; bus.PREADY = 1'b0;
        tick();
        check("stall idle PSEL", 32'(bus.PSEL), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
